// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and default sizing for the pipeline stall controller.
// Latency/backpressure: n/a (types and constants only).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MD_BUSY   = 2'd1,
    MEM_STALL = 2'd2
  } stall_state_t;

  localparam int MD_TIMEOUT_DEF  = 64;
  localparam int MEM_TIMEOUT_DEF = 256;
  localparam int CNT_W_DEF       = 32;

endpackage

// File: rtl/stall_timer.sv
// Clear/enable up-counter that saturates at LIMIT; tc flags the cycle whose increment reaches LIMIT.
// Latency: count registered, tc combinational from the count; no backpressure.
module stall_timer #(
  parameter int LIMIT = 64,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  // clr with en restarts at 1 so the request cycle itself is counted
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= en ? W'(1) : '0;
    end else if (en && cnt != W'(LIMIT)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Merges load-use, mul/div, memory-wait and branch requests into per-stage write/bubble/flush controls.
// Latency: controls are combinational (0 cycles); a frozen pipeline stays frozen until its source releases it.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT  = MD_TIMEOUT_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             mem_wait,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             err_md,
  output logic             err_mem
);

  stall_state_t state, state_n;
  logic done_pending, done_pending_n;
  logic freeze, flush_inc, err_md_set, err_mem_set;
  logic md_en, mem_en, md_tc, mem_tc;

  stall_timer #(.LIMIT(MD_TIMEOUT)) u_md_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state != MD_BUSY),
    .en    (md_en),
    .tc    (md_tc)
  );

  stall_timer #(.LIMIT(MEM_TIMEOUT)) u_mem_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state != MEM_STALL),
    .en    (mem_en),
    .tc    (mem_tc)
  );

  always_comb begin
    state_n        = state;
    done_pending_n = done_pending;
    freeze         = 1'b0;
    flush_inc      = 1'b0;
    err_md_set     = 1'b0;
    err_mem_set    = 1'b0;
    md_en          = 1'b0;
    mem_en         = 1'b0;
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_write     = 1'b1;
    idex_bubble    = 1'b0;
    exmem_write    = 1'b1;
    memwb_bubble   = 1'b0;

    if (reset) begin
      pc_write       = 1'b0;
      ifid_write     = 1'b0;
      ifid_flush     = 1'b1;
      idex_write     = 1'b0;
      idex_bubble    = 1'b1;
      exmem_write    = 1'b0;
      memwb_bubble   = 1'b1;
      state_n        = RUN;
      done_pending_n = 1'b0;
    end else if (state == MD_BUSY) begin
      if ((md_done || done_pending) && !mem_wait) begin
        // release cycle: EX/MEM captures the mul/div result
        state_n        = RUN;
        done_pending_n = 1'b0;
      end else begin
        freeze = 1'b1;
        if (md_done || done_pending) begin
          done_pending_n = 1'b1;
        end else begin
          md_en = 1'b1;
          if (md_tc) begin
            err_md_set = 1'b1;
            state_n    = RUN;
          end
        end
      end
    end else if (state == MEM_STALL && mem_wait) begin
      freeze      = 1'b1;
      mem_en      = 1'b1;
      err_mem_set = mem_tc;
    end else begin
      // RUN, or MEM_STALL resolving: the priority chain acts in this same cycle
      state_n = RUN;
      if (mem_wait) begin
        freeze  = 1'b1;
        mem_en  = 1'b1;
        state_n = MEM_STALL;
      end else if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        flush_inc   = 1'b1;
      end else if (md_start) begin
        freeze  = 1'b1;
        md_en   = 1'b1;
        state_n = MD_BUSY;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end

    if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      done_pending <= 1'b0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      err_md       <= 1'b0;
      err_mem      <= 1'b0;
    end else begin
      state        <= state_n;
      done_pending <= done_pending_n;
      if (!pc_write) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
      if (err_md_set) err_md <= 1'b1;
      if (err_mem_set) err_mem <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios plus random traffic against a transaction-level model.
module tb_pipeline_stall_controller;

  localparam int MD_TO  = 8;
  localparam int MEM_TO = 12;
  localparam int CW     = 32;

  // output patterns {pc_w, ifid_w, ifid_flush, idex_w, idex_bubble, exmem_w, memwb_bubble}
  localparam logic [6:0] C_RESET   = 7'b0010101;
  localparam logic [6:0] C_RUN     = 7'b1101010;
  localparam logic [6:0] C_FREEZE  = 7'b0000001;
  localparam logic [6:0] C_FLUSH   = 7'b1111110;
  localparam logic [6:0] C_LOADUSE = 7'b0001110;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_use = 1'b0, branch_taken = 1'b0, md_start = 1'b0, md_done = 1'b0, mem_wait = 1'b0;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic err_md, err_mem;
  logic [6:0] ctl;

  int checks = 0;
  int errors = 0;

  pipeline_stall_controller #(
    .MD_TIMEOUT (MD_TO),
    .MEM_TIMEOUT(MEM_TO),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .md_start     (md_start),
    .md_done      (md_done),
    .mem_wait     (mem_wait),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_bubble  (idex_bubble),
    .exmem_write  (exmem_write),
    .memwb_bubble (memwb_bubble),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .err_md       (err_md),
    .err_mem      (err_mem)
  );

  assign ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble};

  always #5 clk = ~clk;

  // Model: an outstanding mul/div op with its age, a memory-wait run length, sticky errors, event totals.
  bit            m_md_active = 0, m_md_got = 0, m_in_mem = 0, m_err_md = 0, m_err_mem = 0;
  int            m_md_age = 0, m_mem_run = 0;
  logic [CW-1:0] m_stall = '0, m_flush = '0;
  bit            n_md_active, n_md_got, n_in_mem, n_err_md, n_err_mem;
  int            n_md_age, n_mem_run;
  logic [CW-1:0] n_stall, n_flush;
  logic [6:0]    e_ctl;
  bit            have_nxt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    n_md_active = m_md_active; n_md_got = m_md_got; n_in_mem = m_in_mem;
    n_err_md = m_err_md; n_err_mem = m_err_mem; n_md_age = m_md_age;
    n_mem_run = m_mem_run; n_stall = m_stall; n_flush = m_flush;
    if (reset) begin
      e_ctl = C_RESET;
      n_md_active = 0; n_md_got = 0; n_in_mem = 0; n_err_md = 0; n_err_mem = 0;
      n_md_age = 0; n_mem_run = 0; n_stall = '0; n_flush = '0;
    end else begin
      if (m_md_active) begin
        e_ctl = C_FREEZE;
        if ((md_done || m_md_got) && !mem_wait) begin
          e_ctl = C_RUN;
          n_md_active = 0;
          n_md_got = 0;
        end else if (md_done || m_md_got) begin
          n_md_got = 1;
        end else if (m_md_age + 1 >= MD_TO) begin
          n_err_md = 1;
          n_md_active = 0;
        end else begin
          n_md_age = m_md_age + 1;
        end
      end else if (m_in_mem && mem_wait) begin
        e_ctl = C_FREEZE;
        n_mem_run = m_mem_run + 1;
        if (n_mem_run >= MEM_TO) n_err_mem = 1;
      end else begin
        n_in_mem = 0;
        if (mem_wait) begin
          e_ctl = C_FREEZE; n_in_mem = 1; n_mem_run = 1;
        end else if (branch_taken) begin
          e_ctl = C_FLUSH; n_flush = m_flush + 1;
        end else if (md_start) begin
          e_ctl = C_FREEZE; n_md_active = 1; n_md_age = 1; n_md_got = 0;
        end else if (load_use) begin
          e_ctl = C_LOADUSE;
        end else begin
          e_ctl = C_RUN;
        end
      end
      if (!e_ctl[6]) n_stall = m_stall + 1;
    end
  endtask

  always @(negedge clk) begin
    model_eval();
    check("ctl", ctl, e_ctl);
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
    check("err_md", err_md, m_err_md);
    check("err_mem", err_mem, m_err_mem);
    have_nxt = 1;
  end

  always @(posedge clk) begin
    if (have_nxt) begin
      m_md_active = n_md_active; m_md_got = n_md_got; m_in_mem = n_in_mem;
      m_err_md = n_err_md; m_err_mem = n_err_mem; m_md_age = n_md_age;
      m_mem_run = n_mem_run; m_stall = n_stall; m_flush = n_flush;
    end
  end

  task automatic cyc(input bit r, input bit lu, input bit br, input bit ms, input bit md, input bit mw);
    @(posedge clk);
    #1;
    reset = r; load_use = lu; branch_taken = br; md_start = ms; md_done = md; mem_wait = mw;
    @(negedge clk);
  endtask

  bit r_r, r_lu, r_br, r_ms, r_md, r_mw;
  int mw_left;

  initial begin
    // reset values, then a single load-use stall
    cyc(1, 0, 0, 0, 0, 0);
    check("rst_pc_write", pc_write, 0);
    check("rst_ifid_flush", ifid_flush, 1);
    check("rst_idex_bubble", idex_bubble, 1);
    check("rst_memwb_bubble", memwb_bubble, 1);
    check("rst_exmem_write", exmem_write, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("lu_pc_write", pc_write, 0);
    check("lu_ifid_write", ifid_write, 0);
    check("lu_idex_bubble", idex_bubble, 1);
    check("lu_exmem_write", exmem_write, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("lu_after_pc_write", pc_write, 1);
    check("lu_after_ifid_write", ifid_write, 1);
    check("lu_stall_cnt", stall_cnt, 1);

    // branch wins over load-use
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    check("br_pc_write", pc_write, 1);
    check("br_ifid_flush", ifid_flush, 1);
    check("br_idex_bubble", idex_bubble, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("br_flush_cnt", flush_cnt, 1);
    check("br_stall_cnt", stall_cnt, 0);

    // mul/div with done five cycles later
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("md_c0_pc_write", pc_write, 0);
    for (int i = 1; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("md_frozen_pc_write", pc_write, 0);
    end
    cyc(0, 0, 0, 0, 1, 0);
    check("md_rel_pc_write", pc_write, 1);
    check("md_rel_exmem_write", exmem_write, 1);
    check("md_rel_memwb_bubble", memwb_bubble, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("md_stall_cnt", stall_cnt, 5);

    // done arrives during a memory wait and is held until the wait ends
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    check("dp_c4_pc_write", pc_write, 0);
    for (int i = 5; i < 8; i++) cyc(0, 0, 0, 0, 0, 1);
    check("dp_c7_pc_write", pc_write, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("dp_c8_pc_write", pc_write, 1);
    check("dp_c8_exmem_write", exmem_write, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("dp_stall_cnt", stall_cnt, 8);

    // mul/div timeout with no done
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 1; i < 7; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("to_c7_memwb_bubble", memwb_bubble, 1);
    check("to_c7_pc_write", pc_write, 0);
    check("to_c7_err_md", err_md, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("to_c8_err_md", err_md, 1);
    check("to_c8_pc_write", pc_write, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    check("to_sticky_err_md", err_md, 1);

    // reset in the middle of a mul/div stall
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("rmd_busy_pc_write", pc_write, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("rmd_pc_write", pc_write, 0);
    check("rmd_ifid_flush", ifid_flush, 1);
    check("rmd_idex_bubble", idex_bubble, 1);
    check("rmd_memwb_bubble", memwb_bubble, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("rmd_after_pc_write", pc_write, 1);
    check("rmd_after_err_md", err_md, 0);
    check("rmd_after_stall_cnt", stall_cnt, 0);

    // memory-wait timeout, then load-use acted on in the cycle the wait ends
    for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("mto_c11_err_mem", err_mem, 0);
    cyc(0, 0, 0, 0, 0, 1);
    check("mto_c12_err_mem", err_mem, 1);
    check("mto_c12_pc_write", pc_write, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("mto_lu_pc_write", pc_write, 0);
    check("mto_lu_idex_bubble", idex_bubble, 1);
    check("mto_lu_exmem_write", exmem_write, 1);
    check("mto_stall_cnt", stall_cnt, 13);

    // random traffic, checked every cycle by the model
    cyc(1, 0, 0, 0, 0, 0);
    mw_left = 0;
    for (int i = 0; i < 4000; i++) begin
      r_r  = ($urandom_range(0, 999) < 4);
      r_lu = ($urandom_range(0, 99) < 20);
      r_br = ($urandom_range(0, 99) < 10);
      r_ms = ($urandom_range(0, 99) < 6);
      r_md = ($urandom_range(0, 99) < 8);
      if (mw_left == 0 && $urandom_range(0, 99) < 8) mw_left = $urandom_range(1, 18);
      r_mw = (mw_left != 0);
      if (mw_left != 0) mw_left--;
      cyc(r_r, r_lu, r_br, r_ms, r_md, r_mw);
    end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage pipeline's stall, freeze and flush controls.
- Merges four request sources into one consistent set of per-stage write-enable, bubble and flush signals:
  - load-use hazard (from the hazard detection unit);
  - multi-cycle mul/div unit in EX;
  - data-memory wait;
  - taken branch/jump resolved in EX.
- Sits between those sources and the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Also keeps stall/flush performance counters and a sticky timeout error.

Parameters:
- MD_TIMEOUT, 64: max cycles in MD_BUSY before abort and err_md set.
- MEM_TIMEOUT, 256: max consecutive mem_wait cycles before err_mem set.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- load_use  in  1  load-use hazard request; combinational from the hazard detection unit.
- branch_taken  in  1  EX resolved a taken branch or jump.
- md_start  in  1  mul/div instruction entered EX (1-cycle pulse).
- md_done  in  1  mul/div result valid (1-cycle pulse).
- mem_wait  in  1  data memory not ready; level signal.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID cleared to NOP.
- idex_write  out  1  ID/EX register enable.
- idex_bubble  out  1  ID/EX control fields zeroed.
- exmem_write  out  1  EX/MEM register enable.
- memwb_bubble  out  1  MEM/WB control fields zeroed.
- stall_cnt  out  CNT_W  cycles with pc_write=0, excluding reset.
- flush_cnt  out  CNT_W  number of branch flushes.
- err_md  out  1  sticky: mul/div timeout.
- err_mem  out  1  sticky: memory wait timeout.

Behaviour:
- Registered: state {RUN, MD_BUSY, MEM_STALL}, md_cnt, mem_cnt, done_pending, both perf counters, both error flags. Stage controls are combinational from state and current inputs; zero-latency response is required.
- Reset (reset=1 at a rising edge):
  - state=RUN; all counters, done_pending and error flags cleared.
  - While reset is high: all *_write=0, ifid_flush=1, idex_bubble=1, memwb_bubble=1.
  - Reset mid-operation abandons any stall; no done is remembered.
- Default (RUN, no request): all *_write=1; flush/bubble=0.
- Priority in RUN, highest first. mem_wait:
  - pc/ifid/idex/exmem_write=0, memwb_bubble=1.
  - Next state MEM_STALL, mem_cnt=1.
  - branch_taken/md_start/load_use are held, not acted on; sources keep them asserted since the pipeline is frozen.
- Priority 2, branch_taken:
  - pc_write=1, ifid_flush=1, idex_bubble=1; flush_cnt+1.
  - load_use is ignored (wrong path).
  - md_start in the same cycle is ignored.
- Priority 3, md_start:
  - pc/ifid/idex/exmem_write=0; memwb_bubble=1.
  - Next state MD_BUSY, md_cnt=1.
- Priority 4, load_use:
  - pc_write=0, ifid_write=0, idex_bubble=1; exmem_write=1.
  - Single cycle, no state change.
- MEM_STALL:
  - Outputs frozen as above while mem_wait=1; mem_cnt increments.
  - When mem_cnt reaches MEM_TIMEOUT: err_mem=1 (sticky); remain frozen.
  - mem_wait=0: go to RUN and evaluate the RUN priority chain in that same cycle.
- MD_BUSY:
  - Frozen outputs as for md_start; md_cnt increments.
  - md_done=1 and mem_wait=0: release cycle with all writes=1, exmem captures the result; next state RUN.
  - md_done=1 and mem_wait=1: set done_pending, stay frozen. Release on the first cycle with mem_wait=0, then go to RUN.
  - md_cnt reaches MD_TIMEOUT without done: err_md=1, memwb_bubble=1 that cycle, go to RUN (result discarded).
  - branch_taken/load_use are ignored in MD_BUSY.
- Counters wrap at 2^CNT_W. stall_cnt increments on every non-reset cycle with pc_write=0.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - typedef enum logic [1:0] stall_state_t {RUN, MD_BUSY, MEM_STALL};
  - default constants MD_TIMEOUT_DEF=64, MEM_TIMEOUT_DEF=256, CNT_W_DEF=32.
- One sub-module, stall_timer: a clear/enable counter with terminal-count output, parameterised width and limit. Instantiated twice (md_cnt, mem_cnt).

Test Plan:
- load_use=1 for 1 cycle in RUN -> that cycle pc_write=0, ifid_write=0, idex_bubble=1, exmem_write=1; stall_cnt=1; next cycle all writes=1.
- branch_taken=1 and load_use=1 together -> pc_write=1, ifid_flush=1, idex_bubble=1; flush_cnt=1, stall_cnt=0.
- md_start, md_done 5 cycles later -> pc_write=0 for cycles 0..4, release at cycle 5 with all writes=1; stall_cnt=5.
- md_start, mem_wait high cycles 3..7, md_done at cycle 4 -> frozen through cycle 7; release at cycle 8 via done_pending.
- md_start with MD_TIMEOUT=8 and no done -> err_md=1 at cycle 7, state RUN at cycle 8; err_md stays 1 until reset.
- reset asserted during MD_BUSY -> next cycle state RUN, counters 0, err flags 0; outputs show reset values while reset is high.
